serial_sub_ctrl: RTL and testbench

//  Bit-serial subtract sequencer. Computes a - b over WIDTH cycles using one
//  1-bit subtract cell (two half-subtractor stages plus a borrow OR).

---
 rtl/serial_sub_pkg.sv | 16 +
 rtl/serial_sub_ctrl_if.sv | 25 ++
 rtl/sub_bit_cell.sv | 19 +
 rtl/serial_sub_ctrl.sv | 113 +++++++++++
 tb/tb_serial_sub_ctrl.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/serial_sub_pkg.sv
// Shared types and helpers for the bit-serial subtract sequencer.
package serial_sub_pkg;

  // Sequencer states, fixed 2-bit encoding.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  // Bit counter width: one spare bit so the terminal count WIDTH-1 never wraps.
  function automatic int cnt_width(input int width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/serial_sub_ctrl_if.sv
// Requester <-> subtract sequencer handshake and operand/result bus.
interface serial_sub_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ready;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow_out;

  // Requester side: issues operands, observes status and result.
  modport master (
    output start, a, b,
    input  ready, busy, done, diff, borrow_out
  );

  // Sequencer side.
  modport slave (
    input  start, a, b,
    output ready, busy, done, diff, borrow_out
  );
endinterface

// File: rtl/sub_bit_cell.sv
// One-bit full subtractor built from two half-subtractor stages.
module sub_bit_cell (
  input  logic ai,
  input  logic bi,
  input  logic bin,
  output logic d,
  output logic bout
);
  logic hs1_diff;
  logic hs1_borrow;
  logic hs2_borrow;

  // First stage subtracts bi from ai, second subtracts the incoming borrow.
  assign hs1_diff   = ai ^ bi;
  assign hs1_borrow = ~ai & bi;
  assign d          = hs1_diff ^ bin;
  assign hs2_borrow = ~hs1_diff & bin;
  assign bout       = hs1_borrow | hs2_borrow;
endmodule

// File: rtl/serial_sub_ctrl.sv
// Bit-serial a - b sequencer: latches operands, walks them LSB first through
// a single subtract cell, then presents the result for one DONE cycle.
module serial_sub_ctrl
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic            clk,
  input  logic            rst,
  serial_sub_ctrl_if.slave bus
);
  localparam int CW = cnt_width(WIDTH);

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             brw_q, brw_d;
  logic             borrow_out_q, borrow_out_d;
  logic             ready_q, ready_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             cell_d;
  logic             cell_bout;

  sub_bit_cell u_cell (
    .ai   (a_sh_q[0]),
    .bi   (b_sh_q[0]),
    .bin  (brw_q),
    .d    (cell_d),
    .bout (cell_bout)
  );

  // Next-state, datapath shifting and registered-output decode.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    a_sh_d       = a_sh_q;
    b_sh_d       = b_sh_q;
    res_d        = res_q;
    diff_d       = diff_q;
    brw_d        = brw_q;
    borrow_out_d = borrow_out_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_sh_d  = bus.a;
          b_sh_d  = bus.b;
          brw_d   = 1'b0;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        // Difference bits enter at the MSB end, so after WIDTH shifts
        // bit 0 of the result sits at bit 0.
        a_sh_d            = a_sh_q >> 1;
        b_sh_d            = b_sh_q >> 1;
        res_d             = res_q >> 1;
        res_d[WIDTH-1]    = cell_d;
        brw_d             = cell_bout;
        cnt_d             = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d      = DONE;
          diff_d       = res_d;
          borrow_out_d = cell_bout;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    ready_d = (state_d == IDLE);
    busy_d  = (state_d == RUN);
    done_d  = (state_d == DONE);
  end

  // State and datapath registers; reset abandons any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      a_sh_q       <= '0;
      b_sh_q       <= '0;
      res_q        <= '0;
      diff_q       <= '0;
      brw_q        <= 1'b0;
      borrow_out_q <= 1'b0;
      ready_q      <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      a_sh_q       <= a_sh_d;
      b_sh_q       <= b_sh_d;
      res_q        <= res_d;
      diff_q       <= diff_d;
      brw_q        <= brw_d;
      borrow_out_q <= borrow_out_d;
      ready_q      <= ready_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign bus.ready      = ready_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.diff       = diff_q;
  assign bus.borrow_out = borrow_out_q;
endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Directed and random checks of serial_sub_ctrl at WIDTH=8 and WIDTH=1.
module tb_serial_sub_ctrl;
  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  serial_sub_ctrl_if #(.WIDTH(8)) if8 ();
  serial_sub_ctrl_if #(.WIDTH(1)) if1 ();

  serial_sub_ctrl #(.WIDTH(8)) u_dut8 (.clk(clk), .rst(rst), .bus(if8));
  serial_sub_ctrl #(.WIDTH(1)) u_dut1 (.clk(clk), .rst(rst), .bus(if1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] d;
    logic       br;
  } vec_t;

  vec_t vecs8[6];
  vec_t vecs1[4];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  task automatic drv(input bit w1, input logic s, input logic [7:0] a, input logic [7:0] b);
    if (w1) begin
      if1.start = s; if1.a = a[0]; if1.b = b[0];
    end else begin
      if8.start = s; if8.a = a; if8.b = b;
    end
  endtask

  task automatic smp(input bit w1, output logic dn, output logic rdy, output logic bsy,
                     output logic br, output logic [7:0] df);
    if (w1) begin
      dn = if1.done; rdy = if1.ready; bsy = if1.busy; br = if1.borrow_out; df = {7'b0, if1.diff};
    end else begin
      dn = if8.done; rdy = if8.ready; bsy = if8.busy; br = if8.borrow_out; df = if8.diff;
    end
  endtask

  // One full operation with latency, hold, handshake and pulse-width checks.
  task automatic op(input bit w1, input logic [7:0] a, input logic [7:0] b,
                    input logic [7:0] exp_d, input logic exp_b, input string tag);
    int         w;
    int         lat;
    bit         seen;
    bit         held_ok;
    bit         rdy_ok;
    logic       dn, rdy, bsy, br;
    logic [7:0] df, prev_d;
    logic       prev_b;
    w = w1 ? 1 : 8;
    @(negedge clk);
    smp(w1, dn, rdy, bsy, br, df);
    prev_d = df; prev_b = br;
    chk({tag, "_ready_idle"}, {31'b0, rdy}, 32'd1);
    drv(w1, 1'b1, a, b);
    @(posedge clk);
    @(negedge clk);
    drv(w1, 1'b0, 8'($urandom), 8'($urandom));
    smp(w1, dn, rdy, bsy, br, df);
    chk({tag, "_busy_run"}, {30'b0, bsy, rdy}, 32'd2);
    held_ok = 1; rdy_ok = 1; seen = 0; lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      smp(w1, dn, rdy, bsy, br, df);
      if (rdy !== 1'b0) rdy_ok = 0;
      if (dn === 1'b1) begin
        seen = 1; lat = k;
        break;
      end
      if (df !== prev_d || br !== prev_b) held_ok = 0;
    end
    chk({tag, "_done_seen"}, {31'b0, seen}, 32'd1);
    chk({tag, "_latency"}, lat, w);
    chk({tag, "_diff"}, {24'b0, df}, {24'b0, exp_d});
    chk({tag, "_borrow"}, {31'b0, br}, {31'b0, exp_b});
    chk({tag, "_held"}, {31'b0, held_ok}, 32'd1);
    chk({tag, "_ready_low"}, {31'b0, rdy_ok}, 32'd1);
    $display("op %s w=%0d a=%0h b=%0h diff=%0h borrow=%0b lat=%0d", tag, w, a, b, df, br, lat);
    @(negedge clk);
    smp(w1, dn, rdy, bsy, br, df);
    chk({tag, "_pulse"}, {31'b0, dn}, 32'd0);
    chk({tag, "_diff_hold"}, {23'b0, br, df}, {23'b0, exp_b, exp_d});
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] ra, rb, ed;
    logic       eb;
    bit         seen;
    bit         rdy_ok;
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1;
    drv(0, 1'b0, 8'h00, 8'h00);
    drv(1, 1'b0, 8'h00, 8'h00);

    vecs8[0] = '{8'd100, 8'd37, 8'd63, 1'b0};
    vecs8[1] = '{8'd5,   8'd9,  8'hFC, 1'b1};
    vecs8[2] = '{8'h00,  8'hFF, 8'h01, 1'b1};
    vecs8[3] = '{8'hAA,  8'hAA, 8'h00, 1'b0};
    vecs8[4] = '{8'hFF,  8'h00, 8'hFF, 1'b0};
    vecs8[5] = '{8'h80,  8'h01, 8'h7F, 1'b0};
    vecs1[0] = '{8'h0, 8'h0, 8'h0, 1'b0};
    vecs1[1] = '{8'h0, 8'h1, 8'h1, 1'b1};
    vecs1[2] = '{8'h1, 8'h0, 8'h1, 1'b0};
    vecs1[3] = '{8'h1, 8'h1, 8'h0, 1'b0};

    // Reset state.
    repeat (3) @(negedge clk);
    chk("rst_ready", {31'b0, if8.ready}, 32'd1);
    chk("rst_busy", {31'b0, if8.busy}, 32'd0);
    chk("rst_done", {31'b0, if8.done}, 32'd0);
    chk("rst_diff", {24'b0, if8.diff}, 32'd0);
    chk("rst_borrow", {31'b0, if8.borrow_out}, 32'd0);
    rst = 1'b0;

    // Directed vector tables.
    for (int i = 0; i < 6; i++)
      op(0, vecs8[i].a, vecs8[i].b, vecs8[i].d, vecs8[i].br, $sformatf("vec8_%0d", i));
    for (int i = 0; i < 4; i++)
      op(1, vecs1[i].a, vecs1[i].b, vecs1[i].d, vecs1[i].br, $sformatf("vec1_%0d", i));

    // start held high with new operands while busy: ignored until IDLE.
    @(negedge clk);
    drv(0, 1'b1, 8'd100, 8'd37);
    @(posedge clk);
    @(negedge clk);
    drv(0, 1'b1, 8'd1, 8'd2);
    rdy_ok = 1; seen = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (if8.ready !== 1'b0) rdy_ok = 0;
      if (if8.done === 1'b1) begin seen = 1; break; end
    end
    chk("hold_done_seen", {31'b0, seen}, 32'd1);
    chk("hold_diff", {24'b0, if8.diff}, 32'd63);
    chk("hold_borrow", {31'b0, if8.borrow_out}, 32'd0);
    chk("hold_ready_low", {31'b0, rdy_ok}, 32'd1);
    $display("op hold_first a=64 b=25 diff=%0h borrow=%0b", if8.diff, if8.borrow_out);
    @(negedge clk);
    chk("hold_idle_ready", {31'b0, if8.ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    drv(0, 1'b0, 8'h00, 8'h00);
    seen = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (if8.done === 1'b1) begin seen = 1; break; end
    end
    chk("hold2_done_seen", {31'b0, seen}, 32'd1);
    chk("hold2_diff", {24'b0, if8.diff}, 32'hFF);
    chk("hold2_borrow", {31'b0, if8.borrow_out}, 32'd1);
    $display("op hold_second a=1 b=2 diff=%0h borrow=%0b", if8.diff, if8.borrow_out);
    @(negedge clk);
    chk("hold2_pulse", {31'b0, if8.done}, 32'd0);

    // Reset in the fourth RUN cycle.
    @(negedge clk);
    drv(0, 1'b1, 8'h30, 8'h10);
    @(posedge clk);
    @(negedge clk);
    drv(0, 1'b0, 8'h00, 8'h00);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_diff", {24'b0, if8.diff}, 32'd0);
    chk("midrst_borrow", {31'b0, if8.borrow_out}, 32'd0);
    chk("midrst_ready", {31'b0, if8.ready}, 32'd1);
    chk("midrst_busy", {31'b0, if8.busy}, 32'd0);
    chk("midrst_done", {31'b0, if8.done}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (if8.done !== 1'b0) seen = 1;
    end
    chk("midrst_no_done", {31'b0, seen}, 32'd0);
    $display("op midrst abandoned a=30 b=10");
    op(0, 8'h30, 8'h10, 8'h20, 1'b0, "post_rst");

    // Random sweep against the arithmetic model.
    for (int i = 0; i < 1000; i++) begin
      ra = 8'($urandom); rb = 8'($urandom);
      ed = ra - rb; eb = (ra < rb);
      op(0, ra, rb, ed, eb, "rnd8");
    end
    for (int i = 0; i < 1000; i++) begin
      ra = {7'b0, 1'($urandom)}; rb = {7'b0, 1'($urandom)};
      ed = (ra - rb) & 8'h01; eb = (ra < rb);
      op(1, ra, rb, ed, eb, "rnd1");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
